// File: rtl/exec_ctrl.sv
// Y86 execute-stage controller: selects ALU operands and function, registers the
// result, condition outcome and status behind a one-deep valid/ready output stage.
module exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic [1:0]  alu_control,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    input  logic [63:0] alu_result,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valE,
    output logic        cnd,
    output logic [2:0]  cc,
    output logic [1:0]  stat
);

    // Handshake: a transfer happens on an edge where valid && ready are both 1.
    // Upstream offers an instruction with in_valid and it is taken when in_ready
    // is also high; the held result is consumed when out_valid && out_ready.
    // valid never depends on ready, and a held result never changes until taken.

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_INS = 2'b10;

    localparam logic [63:0] MINUS_8 = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] PLUS_8  = 64'd8;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    state_t      state;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        instr_ok;
    logic        cond_met;
    logic        cnd_next;
    logic [1:0]  stat_next;
    logic        accept;
    logic        zf;
    logic        sf;
    logic        of;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    // op_a/op_b are the architectural aluA/aluB; the ALU sees them swapped so
    // that subtraction and the stack adjustments come out as valB - valA / valB +- 8.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (icode)
            I_RRMOVQ: op_a = valA;
            I_IRMOVQ: op_a = valC;
            I_RMMOVQ, I_MRMOVQ: begin
                op_a = valC;
                op_b = valB;
            end
            I_OPQ: begin
                op_a = valA;
                op_b = valB;
            end
            I_CALL, I_PUSHQ: begin
                op_a = MINUS_8;
                op_b = valB;
            end
            I_RET, I_POPQ: begin
                op_a = PLUS_8;
                op_b = valB;
            end
            default: begin
                op_a = '0;
                op_b = '0;
            end
        endcase
    end

    assign alu_a       = op_b;
    assign alu_b       = op_a;
    assign alu_control = (icode == I_OPQ) ? ifun[1:0] : 2'b00;

    always_comb begin
        instr_ok = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ: instr_ok = (ifun == 4'd0);
            I_RRMOVQ, I_JXX:                instr_ok = (ifun <= 4'd6);
            I_OPQ:                          instr_ok = (ifun <= 4'd3);
            default:                        instr_ok = 1'b0;
        endcase
    end

    // Condition evaluation always uses the flags as they stand before this edge.
    always_comb begin
        cond_met = 1'b0;
        case (ifun)
            4'd0:    cond_met = 1'b1;
            4'd1:    cond_met = (sf ^ of) | zf;
            4'd2:    cond_met = sf ^ of;
            4'd3:    cond_met = zf;
            4'd4:    cond_met = !zf;
            4'd5:    cond_met = !(sf ^ of);
            4'd6:    cond_met = !(sf ^ of) && !zf;
            default: cond_met = 1'b0;
        endcase
    end

    assign cnd_next = instr_ok && ((icode == I_RRMOVQ) || (icode == I_JXX)) && cond_met;

    always_comb begin
        stat_next = STAT_AOK;
        if (!instr_ok) begin
            stat_next = STAT_INS;
        end else if (icode == I_HALT) begin
            stat_next = STAT_HLT;
        end
    end

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // A simultaneous drain and accept simply overwrites the output register,
    // so back-to-back instructions flow without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            out_valid <= 1'b0;
            valE      <= '0;
            cnd       <= 1'b0;
            stat      <= STAT_AOK;
            cc        <= 3'b100;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                valE      <= instr_ok ? alu_result : 64'd0;
                cnd       <= cnd_next;
                stat      <= stat_next;
                if ((icode == I_OPQ) && instr_ok) begin
                    cc <= {(alu_result == 64'd0), alu_result[63], alu_overflow};
                end
                if (stat_next != STAT_AOK) begin
                    state <= STOP;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Randomized self-checking bench for exec_ctrl with an external ALU model and
// an instruction-level reference model feeding an expected-result queue.
module tb_exec_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [1:0]  alu_control;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_result;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc;
    logic [1:0]  stat;

    int n_tests;
    int n_fail;

    // expected {valE, cnd, stat} of results accepted but not yet drained
    logic [66:0] exp_q[$];
    logic [2:0]  m_cc;
    logic        m_stop;

    exec_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .icode        (icode),
        .ifun         (ifun),
        .valA         (valA),
        .valB         (valB),
        .valC         (valC),
        .alu_control  (alu_control),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .valE         (valE),
        .cnd          (cnd),
        .cc           (cc),
        .stat         (stat)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- external 64-bit ALU ----------------
    logic [63:0] alu_sum;
    logic [63:0] alu_diff;
    assign alu_sum  = alu_a + alu_b;
    assign alu_diff = alu_a - alu_b;

    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_control)
            2'b00: begin
                alu_result   = alu_sum;
                alu_overflow = (alu_a[63] == alu_b[63]) && (alu_sum[63] != alu_a[63]);
            end
            2'b01: begin
                alu_result   = alu_diff;
                alu_overflow = (alu_a[63] != alu_b[63]) && (alu_diff[63] != alu_a[63]);
            end
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic instr_valid(input logic [3:0] ic, input logic [3:0] fn);
        if (ic == 4'd6) return fn < 4'd4;
        if (ic == 4'd2 || ic == 4'd7) return fn < 4'd7;
        if (ic > 4'd11) return 1'b0;
        return fn == 4'd0;
    endfunction

    // Returns what the ALU port should show: control, alu_a (=aluB), alu_b (=aluA).
    task automatic ref_alu(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                           output logic [1:0] ctl, output logic [63:0] pa, output logic [63:0] pb);
        logic [63:0] alu_a_arch;
        logic [63:0] alu_b_arch;
        alu_a_arch = 64'd0;
        alu_b_arch = 64'd0;
        case (ic)
            4'd2:       alu_a_arch = a;
            4'd3:       alu_a_arch = c;
            4'd4, 4'd5: begin alu_a_arch = c;                   alu_b_arch = b; end
            4'd6:       begin alu_a_arch = a;                   alu_b_arch = b; end
            4'd8, 4'd10: begin alu_a_arch = 64'd0 - 64'd8;      alu_b_arch = b; end
            4'd9, 4'd11: begin alu_a_arch = 64'd8;              alu_b_arch = b; end
            default: ;
        endcase
        ctl = (ic == 4'd6) ? fn[1:0] : 2'b00;
        pa  = alu_b_arch;
        pb  = alu_a_arch;
    endtask

    task automatic ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                            input logic [2:0] cc_in,
                            output logic [63:0] e, output logic cd, output logic [1:0] st,
                            output logic [2:0] cc_out);
        logic ok, z, s, o, ovf;
        ok     = instr_valid(ic, fn);
        e      = 64'd0;
        ovf    = 1'b0;
        cc_out = cc_in;
        cd     = 1'b0;
        st     = !ok ? 2'b10 : (ic == 4'd0 ? 2'b01 : 2'b00);
        if (ok) begin
            case (ic)
                4'd2: e = a;
                4'd3: e = c;
                4'd4, 4'd5: e = c + b;
                4'd6: begin
                    case (fn)
                        4'd0: begin e = b + a; ovf = (a[63] == b[63]) && (e[63] != b[63]); end
                        4'd1: begin e = b - a; ovf = (a[63] != b[63]) && (e[63] != b[63]); end
                        4'd2: e = b & a;
                        default: e = b ^ a;
                    endcase
                    cc_out = {e == 64'd0, e[63], ovf};
                end
                4'd8, 4'd10: e = b - 64'd8;
                4'd9, 4'd11: e = b + 64'd8;
                default: e = 64'd0;
            endcase
            if (ic == 4'd2 || ic == 4'd7) begin
                z = cc_in[2]; s = cc_in[1]; o = cc_in[0];
                case (fn)
                    4'd0: cd = 1'b1;
                    4'd1: cd = (s != o) || z;
                    4'd2: cd = (s != o);
                    4'd3: cd = z;
                    4'd4: cd = !z;
                    4'd5: cd = (s == o);
                    default: cd = (s == o) && !z;
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        logic [66:0] f;
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("cc", 64'(cc), 64'(m_cc));
        if (exp_q.size() != 0) begin
            f = exp_q[0];
            check("valE", valE, f[66:3]);
            check("cnd", 64'(cnd), 64'(f[2]));
            check("stat", 64'(stat), 64'(f[1:0]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic iv, input logic ordy, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [1:0]  ectl;
        logic [63:0] ea, eb, e;
        logic        cd, exp_rdy, acc, pop;
        logic [1:0]  st;
        logic [2:0]  ccn;
        logic [66:0] dropped;
        in_valid = iv; out_ready = ordy; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        #1;
        check_outputs();
        exp_rdy = !m_stop && ((exp_q.size() == 0) || ordy);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        ref_alu(ic, fn, a, b, c, ectl, ea, eb);
        check("alu_control", 64'(alu_control), 64'(ectl));
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        ref_exec(ic, fn, a, b, c, m_cc, e, cd, st, ccn);
        acc = iv && exp_rdy;
        pop = (exp_q.size() != 0) && ordy;
        @(posedge clk);
        if (pop) dropped = exp_q.pop_front();
        if (acc) begin
            exp_q.push_back({e, cd, st});
            m_cc = ccn;
            if (st != 2'b00) m_stop = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_valE", valE, 64'd0);
        check("rst_cnd", 64'(cnd), 64'd0);
        check("rst_stat", 64'(stat), 64'd0);
        check("rst_cc", 64'(cc), 64'(3'b100));
        check("rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        m_cc   = 3'b100;
        m_stop = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'hFFFF_FFFF_FFFF_FFFF;
            5: return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0]  ic, fn;
        logic [63:0] a, b;
        int stop_cycles;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;
        m_cc = 3'b100; m_stop = 1'b0;
        @(negedge clk);
        do_reset();

        // subq equal operands
        step(1, 1, 4'd6, 4'd1, 64'd5, 64'd5, 64'd0);
        check("subq_valE", valE, 64'd0);
        check("subq_cc", 64'(cc), 64'(3'b100));
        check("subq_stat", 64'(stat), 64'd0);

        // addq signed overflow, then jl sees SF^OF = 0
        step(1, 1, 4'd6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        check("addq_valE", valE, 64'h8000_0000_0000_0000);
        check("addq_cc", 64'(cc), 64'(3'b011));
        step(1, 1, 4'd7, 4'd2, 64'd0, 64'd0, 64'd0);
        check("jl_cnd", 64'(cnd), 64'd0);
        check("jl_cc", 64'(cc), 64'(3'b011));

        // stack pointer adjustments leave cc alone
        step(1, 1, 4'hA, 4'd0, 64'd0, 64'h100, 64'd0);
        check("pushq_valE", valE, 64'hF8);
        check("pushq_cc", 64'(cc), 64'(3'b011));
        step(1, 1, 4'hB, 4'd0, 64'd0, 64'h100, 64'd0);
        check("popq_valE", valE, 64'h108);

        // backpressure hold, then back-to-back flow
        step(1, 1, 4'hA, 4'd0, 64'd0, 64'h200, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 4'd6, 4'd0, 64'd9, 64'd9, 64'd0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_valE", valE, 64'h1F8);
        end
        step(1, 1, 4'h9, 4'd0, 64'd0, 64'h300, 64'd0);
        check("b2b_first", valE, 64'h1F8 + 64'h110);
        step(1, 1, 4'h8, 4'd0, 64'd0, 64'h400, 64'd0);
        check("b2b_second_valE", valE, 64'h3F8);
        check("b2b_out_valid", 64'(out_valid), 64'd1);
        step(0, 1, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0);

        // invalid icode stops the block until reset
        step(1, 1, 4'hC, 4'd0, 64'd3, 64'd4, 64'd5);
        check("ins_stat", 64'(stat), 64'(2'b10));
        check("ins_valE", valE, 64'd0);
        step(1, 1, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0);
        check("stop_in_ready", 64'(in_ready), 64'd0);
        do_reset();

        // randomized traffic
        stop_cycles = 0;
        for (int n = 0; n < 2500; n++) begin
            if (m_stop) stop_cycles++;
            if ((m_stop && stop_cycles > 3) ||
                (exp_q.size() != 0 && $urandom_range(0, 99) == 0)) begin
                do_reset();
                stop_cycles = 0;
            end else begin
                if ($urandom_range(0, 99) < 4) begin
                    ic = 4'($urandom_range(0, 15));
                    fn = 4'($urandom_range(0, 15));
                end else begin
                    case ($urandom_range(0, 3))
                        0:       ic = 4'd6;
                        1:       ic = 4'd7;
                        default: ic = 4'($urandom_range(1, 11));
                    endcase
                    fn = 4'd0;
                    if (ic == 4'd2 || ic == 4'd7) fn = 4'($urandom_range(0, 6));
                    else if (ic == 4'd6) fn = 4'($urandom_range(0, 3));
                end
                a = rand_val();
                b = ($urandom_range(0, 7) == 0) ? a : rand_val();
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                     ic, fn, a, b, rand_val());
            end
        end
        step(0, 1, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  block accepts instruction this cycle
icode  in  4  Y86 instruction code
ifun  in  4  Y86 function code
valA  in  64  register operand A
valB  in  64  register operand B
valC  in  64  immediate/displacement
alu_control  out  2  to 64-bit ALU: 00 add, 01 sub, 10 and, 11 xor
alu_a  out  64  ALU first operand
alu_b  out  64  ALU second operand
alu_result  in  64  ALU result, combinational from alu_* outputs
alu_overflow  in  1  ALU signed-overflow flag
out_valid  out  1  registered execute result present
out_ready  in  1  downstream accepts result
valE  out  64  registered ALU result
cnd  out  1  registered condition outcome
cc  out  3  condition codes {ZF,SF,OF}
stat  out  2  00 AOK, 01 HLT, 10 INS (invalid instruction)

Function
REQ-002 alu_control/alu_a/alu_b SHALL be combinational from icode/ifun/valA/valB/valC; ALU result = alu_a op alu_b.
REQ-003 Operand select (aluA, aluB): rrmovq(2) valA,0; irmovq(3) valC,0; rmmovq(4)/mrmovq(5) valC,valB; OPq(6) valA,valB; call(8)/pushq(A) -8,valB; ret(9)/popq(B) +8,valB; others 0,0.
REQ-004 alu_a SHALL carry aluB and alu_b SHALL carry aluA, so subq yields valB-valA.
REQ-005 alu_control SHALL equal ifun[1:0] for icode 6, else 00.
REQ-006 Handshake: accept when in_valid && in_ready; in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-007 Latency 1 cycle: on accept, valE<=alu_result, cnd, stat registered and out_valid<=1 next edge.
REQ-008 out_valid SHALL clear on out_ready with no new accept; held result SHALL stay stable while out_valid && !out_ready.
REQ-009 cc SHALL update only on accepted icode 6 with valid ifun: ZF=(alu_result==0), SF=alu_result[63], OF=alu_overflow.
REQ-010 cnd for icode 2 or 7 SHALL use cc before the edge: ifun 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&&!ZF; all other icodes cnd=0.
REQ-011 Invalid: icode>B, icode 6 with ifun>3, icode 2/7 with ifun>6, icode 0/1/3-5/8-B with ifun!=0 -> stat=10, cc unchanged, valE=0.
REQ-012 icode 0 (halt) valid -> stat=01.
REQ-013 FSM states RUN, STOP; RUN->STOP on accepting an instruction with stat!=00; STOP is terminal until rst; in STOP in_ready=0 and cc frozen, with the final result still drained via out_ready.
REQ-014 Simultaneous out_ready and accept SHALL replace output in the same edge without bubble.

Reset
REQ-015 While rst=1 (asynchronous): state=RUN, out_valid=0, valE=0, cnd=0, stat=00, cc={ZF=1,SF=0,OF=0}.
REQ-016 Reset mid-transfer SHALL discard held result and any in-flight instruction.

Verification
REQ-017 OPq subq (icode 6, ifun 1) valA=5, valB=5 -> alu_control=01, alu_a=5, alu_b=5; next cycle valE=0, cc={1,0,0}, stat=00.
REQ-018 addq valA=1, valB=0x7FFFFFFFFFFFFFFF -> valE=0x8000000000000000, cc={0,1,1}; following jXX ifun 2 (jl) -> cnd=0, cc unchanged.
REQ-019 pushq valB=0x100 -> valE=0xF8, cc unchanged; popq valB=0x100 -> valE=0x108.
REQ-020 out_ready=0 for 3 cycles after accept -> in_ready=0, valE stable; out_ready=1 with in_valid=1 -> back-to-back results, no bubble.
REQ-021 icode 0xC -> stat=10, state STOP, in_ready=0 thereafter; assert rst -> stat=00, cc={1,0,0}, in_ready=1.
